// File: rtl/lcd_pkg.sv
// Shared definitions for the SPI LCD byte transmitter: FSM encoding,
// DC polarity constants and default timing parameters.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } lcd_state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int DEF_CLK_DIV_HALF = 2;
    localparam int DEF_GAP_CYCLES   = 3;

endpackage

// File: rtl/lcd_spi_tick.sv
// Half-period timebase: pulses tick_o on the last cycle of every
// CLK_DIV_HALF-cycle window while enabled; held at zero while cleared.
module lcd_spi_tick #(
    parameter int CLK_DIV_HALF = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV_HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV_HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: clear wins over enable, wrap at the end of each half-period
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

    // counter register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_spi_byte_tx.sv
// Serialises one {dc, byte} word onto a 4-wire SPI LCD bus, MSB first, mode 0.
// Every pin is driven straight from a flop; next values are computed one cycle ahead.
module lcd_spi_byte_tx
    import lcd_pkg::*;
#(
    parameter int CLK_DIV_HALF = DEF_CLK_DIV_HALF,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc,
    output logic       lcd_cs_n
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    lcd_state_e    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          phase_q, phase_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          dc_q, dc_d;
    logic          cs_n_q, cs_n_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          tick_s;

    lcd_spi_tick #(.CLK_DIV_HALF(CLK_DIV_HALF)) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr_i     ((state_q == ST_IDLE) || (state_q == ST_GAP)),
        .en_i      ((state_q == ST_SHIFT) || (state_q == ST_HOLD)),
        .tick_o    (tick_s)
    );

    // FSM next state and next pin values (phase_q=0: SCLK low half, 1: high half)
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        dc_d      = dc_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_write) begin
                    state_d   = ST_SHIFT;
                    shift_d   = data[7:0];
                    dc_d      = data[8];
                    mosi_d    = data[7];
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    phase_d   = 1'b0;
                    bit_cnt_d = 3'd0;
                end else begin
                    cs_n_d = 1'b1;
                    sclk_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick_s && !phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else if (tick_s) begin
                    // falling edge: advance to the next bit, or finish after bit 0
                    phase_d   = 1'b0;
                    sclk_d    = 1'b0;
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_HOLD;
                    end else begin
                        mosi_d = shift_q[6];
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    state_d   = ST_GAP;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // state, datapath and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            phase_q   <= 1'b0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dc_q      <= DC_CMD;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            dc_q      <= dc_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_done  = done_q;
    assign busy     = busy_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;
    assign lcd_dc   = dc_q;
    assign lcd_cs_n = cs_n_q;

endmodule

// File: tb/tb_lcd_spi_byte_tx.sv
// Bench for lcd_spi_byte_tx: two instances (half-period 2 and 1), a word
// scoreboard fed by the stimulus and a per-instance bus decoder that checks it.
module tb_lcd_spi_byte_tx;

    localparam int G = 3;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       sys_rst_n;
    logic       en_w [2];
    logic [8:0] din  [2];
    logic       done [2];
    logic       busy [2];
    logic       sclk [2];
    logic       mosi [2];
    logic       dc   [2];
    logic       csn  [2];

    logic [8:0] exp_q[$];
    logic [8:0] stream_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_pushed = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int H = (g == 0) ? 2 : 1;

        lcd_spi_byte_tx #(.CLK_DIV_HALF(H), .GAP_CYCLES(G)) dut (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .en_write  (en_w[g]),
            .data      (din[g]),
            .wr_done   (done[g]),
            .busy      (busy[g]),
            .lcd_sclk  (sclk[g]),
            .lcd_mosi  (mosi[g]),
            .lcd_dc    (dc[g]),
            .lcd_cs_n  (csn[g])
        );

        int         cyc = 0;
        int         t_cs = 0;
        int         t_done = -1000;
        int         rises = 0;
        logic       in_frame = 1'b0;
        logic       prev_sclk = 1'b0;
        logic       prev_mosi = 1'b0;
        logic       dc_v = 1'b0;
        logic       dc_bad = 1'b0;
        logic       mosi_bad = 1'b0;
        logic [7:0] sh = 8'd0;

        // decode the SPI bus as a slave would and score each completed word
        always @(negedge sys_clk) begin : mon
            logic [8:0] e;
            if (!sys_rst_n) begin
                in_frame  = 1'b0;
                prev_sclk = 1'b0;
                prev_mosi = 1'b0;
                t_done    = -1000;
            end else begin
                cyc++;
                if (cyc == t_done + G)     check("busy_last_gap_cycle", busy[g], 1);
                if (cyc == t_done + G + 1) check("busy_low_after_gap", busy[g], 0);
                if (!csn[g] && !in_frame) begin
                    in_frame = 1'b1;
                    t_cs     = cyc;
                    rises    = 0;
                    sh       = 8'd0;
                    dc_v     = dc[g];
                    dc_bad   = 1'b0;
                    mosi_bad = 1'b0;
                    check("frame_spacing_ge_gap", (cyc - t_done) >= (G + 2), 1);
                    check("busy_at_cs_low", busy[g], 1);
                end
                if (in_frame && !csn[g]) begin
                    if (dc[g] !== dc_v) dc_bad = 1'b1;
                    if (sclk[g] && !prev_sclk) begin
                        rises++;
                        sh = {sh[6:0], mosi[g]};
                    end
                    if (sclk[g] && prev_sclk && (mosi[g] !== prev_mosi)) mosi_bad = 1'b1;
                end
                if (done[g]) begin
                    n_done++;
                    check("done_inside_frame", in_frame, 1);
                    check("cs_high_at_done", csn[g], 1);
                    check("done_latency", cyc - t_cs, 17 * H);
                    check("sclk_rising_edges", rises, 8);
                    check("dc_stable_in_frame", dc_bad, 0);
                    check("mosi_stable_sclk_high", mosi_bad, 0);
                    check("done_has_expected_word", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("word_value", {dc_v, sh}, e);
                    end
                    in_frame = 1'b0;
                    t_done   = cyc;
                end
                prev_sclk = sclk[g];
                prev_mosi = mosi[g];
            end
        end
    end

    task automatic check_reset_vals(input int ln);
        check("rst_sclk", sclk[ln], 0);
        check("rst_mosi", mosi[ln], 0);
        check("rst_dc", dc[ln], 0);
        check("rst_cs_n", csn[ln], 1);
        check("rst_wr_done", done[ln], 0);
        check("rst_busy", busy[ln], 0);
    endtask

    task automatic wait_done(input int ln, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (done[ln]) begin
                ok = 1'b1;
                break;
            end
        end
        check("wr_done_within_budget", ok, 1);
    endtask

    task automatic send_single(input int ln, input logic [8:0] w);
        bit ok;
        @(negedge sys_clk);
        din[ln]  = w;
        en_w[ln] = 1'b1;
        exp_q.push_back(w);
        n_pushed++;
        @(negedge sys_clk);
        en_w[ln] = 1'b0;
        din[ln]  = 9'($urandom);
        wait_done(ln, ok);
        repeat (G + 2) @(negedge sys_clk);
    endtask

    // producer in the style of lcd_row_show: en_write held, data updated after each done
    task automatic run_stream(input int ln);
        bit ok;
        int n;
        n = stream_q.size();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(stream_q[i]);
            n_pushed++;
        end
        @(negedge sys_clk);
        din[ln]  = stream_q[0];
        en_w[ln] = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_done(ln, ok);
            if (!ok) break;
            if (i == n - 1) begin
                @(negedge sys_clk);
                en_w[ln] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                repeat (3) @(negedge sys_clk);
                din[ln] = stream_q[i + 1];
            end else begin
                @(negedge sys_clk);
                din[ln] = stream_q[i + 1];
            end
        end
        en_w[ln] = 1'b0;
        repeat (G + 3) @(negedge sys_clk);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        en_w[0] = 1'b0;
        en_w[1] = 1'b0;
        din[0]  = 9'd0;
        din[1]  = 9'd0;
        repeat (3) @(negedge sys_clk);
        check_reset_vals(0);
        check_reset_vals(1);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        send_single(0, 9'h02A);
        send_single(0, 9'h1F8);

        stream_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02B,
                     9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
        run_stream(0);

        stream_q.delete();
        for (int i = 0; i < 20; i++) stream_q.push_back(9'($urandom));
        run_stream(0);

        // abandon a frame during bit 4; it must never complete
        @(negedge sys_clk);
        din[0]  = 9'h155;
        en_w[0] = 1'b1;
        @(negedge sys_clk);
        en_w[0] = 1'b0;
        repeat (17) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_reset_vals(0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        check("no_done_for_aborted_frame", n_done, n_pushed);
        send_single(0, 9'h0C3);

        send_single(1, 9'h02A);
        stream_q.delete();
        for (int i = 0; i < 12; i++) stream_q.push_back(9'($urandom));
        run_stream(1);

        check("scoreboard_drained", exp_q.size(), 0);
        check("done_count", n_done, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
